// File: rtl/bib_qspi_yanitlayici.sv
// Bus-to-QPI flash bridge: a read fetches one word with quad read; a write sends WREN, then page program.
// SCK runs at clk/2; the core is stalled until the one-cycle TAMAM state.
module bib_qspi_yanitlayici #(
  parameter int unsigned DUMMY_CYC = 6,
  parameter logic [7:0]  READ_CMD  = 8'hEB,
  parameter logic [7:0]  WREN_CMD  = 8'h06,
  parameter logic [7:0]  PROG_CMD  = 8'h02
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bib_sec_i,
  input  logic        bib_yaz_gecerli_i,
  input  logic [31:0] bib_adr_i,
  input  logic [31:0] bib_veri_i,
  input  logic [3:0]  bib_veri_maske_i,
  output logic [31:0] bib_veri_o,
  output logic        bib_durdur_o,
  output logic        qspi_sck_o,
  output logic        qspi_cs_n_o,
  output logic [3:0]  qspi_io_o,
  output logic        qspi_oe_o,
  input  logic [3:0]  qspi_io_i
);

  typedef enum logic [2:0] {BOSTA, KOMUT, ADRES, BEKLE, VERI, ARA, BITIR, TAMAM} durum_t;

  localparam logic [3:0] BEKLE_SON = 4'(DUMMY_CYC - 1);

  durum_t      r_durum;
  logic        r_faz;
  logic [3:0]  r_sayac;
  logic        r_yaz;
  logic        r_wren_bitti;
  logic [23:0] r_adr;
  logic [31:0] r_veri;
  logic [1:0]  r_ilk;
  logic [1:0]  r_son;
  logic [31:0] r_rx;
  logic        r_sck;
  logic        r_cs_n;
  logic        r_oe;
  logic [3:0]  r_io;
  logic [31:0] r_veri_o;

  logic [1:0]  w_ilk;
  logic [1:0]  w_son;
  logic [1:0]  w_aralik;
  logic [7:0]  w_komut;
  logic [3:0]  w_son_per;
  logic        w_per_son;
  logic [3:0]  w_sonraki;
  logic [3:0]  w_nib_sonraki;
  logic [4:0]  w_rx_pos;
  logic        w_unused_adr;

  function automatic logic [3:0] f_op_nib(input logic [7:0] op, input logic [3:0] s);
    return s[0] ? op[3:0] : op[7:4];
  endfunction

  function automatic logic [3:0] f_adr_nib(input logic [23:0] a, input logic [3:0] s);
    logic [23:0] t;
    t = a << {s, 2'b00};
    return t[23:20];
  endfunction

  // Byte index walks up from the lowest enabled lane; high nibble goes out first.
  function automatic logic [3:0] f_veri_nib(input logic [31:0] d, input logic [1:0] ilk,
                                            input logic [3:0] s);
    logic [1:0]  b;
    logic [31:0] t;
    b = ilk + s[2:1];
    t = d >> {b, 3'b000};
    return s[0] ? t[3:0] : t[7:4];
  endfunction

  // Lowest and highest enabled lanes; everything in between is written too.
  always_comb begin
    w_ilk = 2'd0;
    w_son = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bib_veri_maske_i[i]) w_ilk = 2'(i);
    end
    for (int i = 0; i < 4; i++) begin
      if (bib_veri_maske_i[i]) w_son = 2'(i);
    end
  end

  assign w_aralik     = r_son - r_ilk;
  assign w_komut      = !r_yaz ? READ_CMD : (r_wren_bitti ? PROG_CMD : WREN_CMD);
  assign w_sonraki    = r_sayac + 4'd1;
  assign w_per_son    = (r_sayac == w_son_per);
  assign w_rx_pos     = {r_sayac[2:1], ~r_sayac[0], 2'b00};
  assign w_unused_adr = ^{bib_adr_i[31:24], bib_adr_i[1:0]};

  always_comb begin
    w_son_per = 4'd0;
    case (r_durum)
      KOMUT:   w_son_per = 4'd1;
      ADRES:   w_son_per = 4'd5;
      BEKLE:   w_son_per = BEKLE_SON;
      VERI:    w_son_per = r_yaz ? {1'b0, w_aralik, 1'b1} : 4'd7;
      default: w_son_per = 4'd0;
    endcase
  end

  always_comb begin
    w_nib_sonraki = 4'h0;
    case (r_durum)
      KOMUT:   w_nib_sonraki = f_op_nib(w_komut, w_sonraki);
      ADRES:   w_nib_sonraki = f_adr_nib(r_adr, w_sonraki);
      VERI:    w_nib_sonraki = r_yaz ? f_veri_nib(r_veri, r_ilk, w_sonraki) : 4'h0;
      default: w_nib_sonraki = 4'h0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_durum      <= BOSTA;
      r_faz        <= 1'b0;
      r_sayac      <= 4'd0;
      r_yaz        <= 1'b0;
      r_wren_bitti <= 1'b0;
      r_adr        <= 24'd0;
      r_veri       <= 32'd0;
      r_ilk        <= 2'd0;
      r_son        <= 2'd0;
      r_rx         <= 32'd0;
      r_sck        <= 1'b0;
      r_cs_n       <= 1'b1;
      r_oe         <= 1'b0;
      r_io         <= 4'h0;
      r_veri_o     <= 32'd0;
    end else begin
      case (r_durum)
        BOSTA: begin
          if (bib_sec_i) begin
            r_yaz        <= bib_yaz_gecerli_i;
            r_veri       <= bib_veri_i;
            r_ilk        <= w_ilk;
            r_son        <= w_son;
            r_adr        <= {bib_adr_i[23:2], bib_yaz_gecerli_i ? w_ilk : 2'b00};
            r_wren_bitti <= 1'b0;
            r_faz        <= 1'b0;
            r_sayac      <= 4'd0;
            if (bib_yaz_gecerli_i && bib_veri_maske_i == 4'b0000) begin
              r_durum <= TAMAM;
            end else begin
              r_durum <= KOMUT;
              r_cs_n  <= 1'b0;
              r_oe    <= 1'b1;
              r_io    <= bib_yaz_gecerli_i ? WREN_CMD[7:4] : READ_CMD[7:4];
            end
          end
        end
        KOMUT, ADRES, BEKLE, VERI: begin
          if (!r_faz) begin
            r_faz <= 1'b1;
            r_sck <= 1'b1;
          end else begin
            r_faz <= 1'b0;
            r_sck <= 1'b0;
            if (r_durum == VERI && !r_yaz) r_rx[w_rx_pos +: 4] <= qspi_io_i;
            if (w_per_son) begin
              r_sayac <= 4'd0;
              case (r_durum)
                KOMUT: begin
                  if (r_yaz && !r_wren_bitti) begin
                    r_durum      <= ARA;
                    r_cs_n       <= 1'b1;
                    r_oe         <= 1'b0;
                    r_io         <= 4'h0;
                    r_wren_bitti <= 1'b1;
                  end else begin
                    r_durum <= ADRES;
                    r_io    <= r_adr[23:20];
                  end
                end
                ADRES: begin
                  if (r_yaz) begin
                    r_durum <= VERI;
                    r_io    <= f_veri_nib(r_veri, r_ilk, 4'd0);
                  end else begin
                    r_durum <= BEKLE;
                    r_oe    <= 1'b0;
                    r_io    <= 4'h0;
                  end
                end
                BEKLE: r_durum <= VERI;
                default: begin
                  r_durum <= BITIR;
                  r_cs_n  <= 1'b1;
                  r_oe    <= 1'b0;
                  r_io    <= 4'h0;
                end
              endcase
            end else begin
              r_sayac <= w_sonraki;
              r_io    <= w_nib_sonraki;
            end
          end
        end
        ARA: begin
          r_durum <= KOMUT;
          r_cs_n  <= 1'b0;
          r_oe    <= 1'b1;
          r_io    <= PROG_CMD[7:4];
          r_faz   <= 1'b0;
          r_sayac <= 4'd0;
        end
        BITIR: begin
          r_durum <= TAMAM;
          if (!r_yaz) r_veri_o <= r_rx;
        end
        TAMAM:   r_durum <= BOSTA;
        default: r_durum <= BOSTA;
      endcase
    end
  end

  // Idle stall follows the select directly so a new request is held off without a bubble.
  assign bib_durdur_o = rst_i & ((r_durum == BOSTA) ? bib_sec_i : (r_durum != TAMAM));
  assign bib_veri_o   = r_veri_o;
  assign qspi_sck_o   = r_sck;
  assign qspi_cs_n_o  = r_cs_n;
  assign qspi_oe_o    = r_oe;
  assign qspi_io_o    = r_io;

endmodule

// File: tb/tb_bib_qspi_yanitlayici.sv
// Bench for bib_qspi_yanitlayici: per-cycle pin waveform and latency compared against a model built from the protocol rules.
module tb_bib_qspi_yanitlayici;
  localparam int DUMMY = 6;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        bib_sec_i;
  logic        bib_yaz_gecerli_i;
  logic [31:0] bib_adr_i;
  logic [31:0] bib_veri_i;
  logic [3:0]  bib_veri_maske_i;
  logic [31:0] bib_veri_o;
  logic        bib_durdur_o;
  logic        qspi_sck_o;
  logic        qspi_cs_n_o;
  logic [3:0]  qspi_io_o;
  logic        qspi_oe_o;
  logic [3:0]  qspi_io_i;

  bib_qspi_yanitlayici #(.DUMMY_CYC(DUMMY)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bib_sec_i(bib_sec_i),
    .bib_yaz_gecerli_i(bib_yaz_gecerli_i), .bib_adr_i(bib_adr_i),
    .bib_veri_i(bib_veri_i), .bib_veri_maske_i(bib_veri_maske_i),
    .bib_veri_o(bib_veri_o), .bib_durdur_o(bib_durdur_o),
    .qspi_sck_o(qspi_sck_o), .qspi_cs_n_o(qspi_cs_n_o), .qspi_io_o(qspi_io_o),
    .qspi_oe_o(qspi_oe_o), .qspi_io_i(qspi_io_i)
  );

  always #5 clk_i = ~clk_i;

  int          n_test = 0;
  int          n_hata = 0;
  logic [31:0] son_okuma = 32'd0;
  logic [6:0]  bek[$];   // {cs_n, sck, oe, io} per clk
  logic [6:0]  goz[$];

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    n_test++;
    if (gozlenen !== beklenen) begin
      n_hata++;
      $display("FAIL %s: gozlenen=%0h beklenen=%0h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic bos_ekle();
    bek.push_back(7'b100_0000);
  endtask

  task automatic per_ekle(input logic oe, input logic [3:0] n);
    logic [3:0] v;
    v = oe ? n : 4'h0;
    bek.push_back({1'b0, 1'b0, oe, v});
    bek.push_back({1'b0, 1'b1, oe, v});
  endtask

  task automatic bayt_ekle(input logic [7:0] b);
    per_ekle(1'b1, b[7:4]);
    per_ekle(1'b1, b[3:0]);
  endtask

  task automatic model_kur(input logic yaz, input logic [31:0] adr, input logic [31:0] veri,
                           input logic [3:0] maske);
    logic [23:0] a;
    int lo, hi;
    bek.delete();
    bos_ekle();
    if (!yaz) begin
      a = {adr[23:2], 2'b00};
      bayt_ekle(8'hEB);
      bayt_ekle(a[23:16]); bayt_ekle(a[15:8]); bayt_ekle(a[7:0]);
      repeat (DUMMY + 8) per_ekle(1'b0, 4'h0);
      bos_ekle();
    end else if (maske != 4'b0000) begin
      lo = 4; hi = -1;
      for (int i = 0; i < 4; i++) if (maske[i]) begin
        if (i < lo) lo = i;
        hi = i;
      end
      a = {adr[23:2], 2'(lo)};
      bayt_ekle(8'h06);
      bos_ekle();
      bayt_ekle(8'h02);
      bayt_ekle(a[23:16]); bayt_ekle(a[15:8]); bayt_ekle(a[7:0]);
      for (int b = lo; b <= hi; b++) bayt_ekle(veri[8*b +: 8]);
      bos_ekle();
    end
    bos_ekle();
  endtask

  // One bus request; kes >= 0 asserts reset in that cycle and returns without completion.
  task automatic islem(input logic yaz, input logic [31:0] adr, input logic [31:0] veri,
                       input logic [3:0] maske, input logic [31:0] fl_veri, input bit tut,
                       input bit hemen, input int kes, input string ad, output int lat);
    int p, j, n, hcs, hsck, hhat;
    bit bitti;
    model_kur(yaz, adr, veri, maske);
    goz.delete();
    if (!hemen) @(posedge clk_i);
    #1;
    bib_sec_i = 1'b1; bib_yaz_gecerli_i = yaz; bib_adr_i = adr;
    bib_veri_i = veri; bib_veri_maske_i = maske;
    p = 0; lat = -1; bitti = 1'b0;
    for (int c = 0; c < 300 && !bitti; c++) begin
      @(negedge clk_i);
      goz.push_back({qspi_cs_n_o, qspi_sck_o, qspi_oe_o, qspi_io_o});
      if (!qspi_cs_n_o && qspi_sck_o) begin
        j = p - 8 - DUMMY;
        if (!yaz && j >= 0 && j < 8) qspi_io_i = fl_veri[8*(j/2) + ((j % 2 == 0) ? 4 : 0) +: 4];
        else qspi_io_i = 4'($urandom);
        p++;
      end
      if (c == kes) begin
        rst_i = 1'b0;
        #1;
        kontrol({ad, "_rst_cs_n"}, qspi_cs_n_o, 1);
        kontrol({ad, "_rst_sck"}, qspi_sck_o, 0);
        kontrol({ad, "_rst_oe_io"}, {qspi_oe_o, qspi_io_o}, 0);
        kontrol({ad, "_rst_durdur"}, bib_durdur_o, 0);
        kontrol({ad, "_rst_veri"}, bib_veri_o, 0);
        son_okuma = 32'd0;
        return;
      end
      if (c > 0 && !bib_durdur_o) begin
        lat = c;
        bitti = 1'b1;
      end
    end
    if (!bitti) begin
      kontrol({ad, "_zaman_asimi"}, 1, 0);
      bib_sec_i = 1'b0;
      return;
    end
    kontrol({ad, "_gecikme"}, lat, bek.size() - 1);
    n = (goz.size() < bek.size()) ? goz.size() : bek.size();
    hcs = 0; hsck = 0; hhat = 0;
    for (int i = 0; i < n; i++) begin
      if (goz[i][6] !== bek[i][6]) hcs++;
      if (goz[i][5] !== bek[i][5]) hsck++;
      if (goz[i][4:0] !== bek[i][4:0]) hhat++;
    end
    kontrol({ad, "_cs_n_hata"}, hcs, 0);
    kontrol({ad, "_sck_hata"}, hsck, 0);
    kontrol({ad, "_oe_io_hata"}, hhat, 0);
    if (!yaz) son_okuma = fl_veri;
    kontrol({ad, "_veri_o"}, bib_veri_o, son_okuma);
    if (!tut) bib_sec_i = 1'b0;
  endtask

  initial begin
    int lat;
    logic yaz;
    rst_i = 1'b0; bib_sec_i = 1'b0; bib_yaz_gecerli_i = 1'b0;
    bib_adr_i = 32'd0; bib_veri_i = 32'd0; bib_veri_maske_i = 4'd0; qspi_io_i = 4'd0;
    repeat (3) @(negedge clk_i);
    kontrol("reset_cs_n", qspi_cs_n_o, 1);
    kontrol("reset_sck", qspi_sck_o, 0);
    kontrol("reset_oe", qspi_oe_o, 0);
    kontrol("reset_io", qspi_io_o, 0);
    kontrol("reset_veri_o", bib_veri_o, 0);
    bib_sec_i = 1'b1;
    #1 kontrol("reset_durdur", bib_durdur_o, 0);
    bib_sec_i = 1'b0;
    @(negedge clk_i) rst_i = 1'b1;

    islem(1'b0, 32'h0000_1006, 32'd0, 4'h0, 32'h4433_2211, 1'b0, 1'b0, -1, "oku_1006", lat);
    kontrol("oku_1006_c46", lat, 46);
    islem(1'b1, 32'h20, 32'hA1B2_C3D4, 4'b1111, 32'd0, 1'b0, 1'b0, -1, "yaz_tam", lat);
    kontrol("yaz_tam_c39", lat, 39);
    islem(1'b1, 32'h20, 32'h00EE_0000, 4'b0100, 32'd0, 1'b0, 1'b0, -1, "yaz_tek", lat);
    kontrol("yaz_tek_c27", lat, 27);
    islem(1'b1, 32'h20, 32'h5566_7788, 4'b1001, 32'd0, 1'b0, 1'b0, -1, "yaz_1001", lat);
    kontrol("yaz_1001_c39", lat, 39);
    islem(1'b1, 32'h20, 32'h1234_5678, 4'b0000, 32'd0, 1'b0, 1'b0, -1, "yaz_bos", lat);
    kontrol("yaz_bos_c1", lat, 1);

    for (int k = 0; k < 12; k++) begin
      yaz = 1'($urandom);
      islem(yaz, $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom,
            1'b0, 1'b0, -1, $sformatf("rast%0d", k), lat);
      if (($urandom_range(0, 1)) == 1) repeat ($urandom_range(1, 4)) @(posedge clk_i);
    end

    islem(1'b0, 32'h00AB_CDE0, 32'd0, 4'h0, $urandom, 1'b1, 1'b0, -1, "arka1", lat);
    islem(1'b0, 32'h0012_3457, 32'd0, 4'h0, $urandom, 1'b1, 1'b0, -1, "arka2", lat);
    kontrol("arka2_c46", lat, 46);
    islem(1'b0, 32'h0000_0100, 32'd0, 4'h0, $urandom, 1'b1, 1'b0, 20, "kesik", lat);
    @(posedge clk_i);
    @(negedge clk_i);
    kontrol("kesik_tutulu_cs_n", qspi_cs_n_o, 1);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    islem(1'b0, 32'h0000_0100, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, -1, "yeniden", lat);
    kontrol("yeniden_c46", lat, 46);

    repeat (3) @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", n_test, n_hata);
    $finish;
  end
endmodule
